// File: rtl/pe_link_pkg.sv
// Shared link-bus layout for the PE link packer: bit positions and the beat
// structures carried on the link and held in the beat FIFO.
package pe_link_pkg;

    localparam int LINK_VALID_BIT = 129;
    localparam int LINK_LAST_BIT  = 128;
    localparam int PAYLOAD_WIDTH  = 128;

    typedef struct packed {
        logic                     valid;
        logic                     last;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } link_beat_t;

    typedef struct packed {
        logic                     last;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } fifo_entry_t;

    function automatic link_beat_t make_link_beat(input fifo_entry_t entry);
        link_beat_t beat;
        beat.valid   = 1'b1;
        beat.last    = entry.last;
        beat.payload = entry.payload;
        return beat;
    endfunction

endpackage

// File: rtl/pe_link_beat_fifo.sv
// Small synchronous beat FIFO; the extra pointer MSB separates full from empty.
module pe_link_beat_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("pe_link_beat_fifo: DEPTH must be a power of two >= 2");
    end

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is never reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/pe_link_packer.sv
// Packs a 32-bit word stream four words per beat, buffers beats and drives the
// registered west link of the neighbouring PE; everything freezes while ap_start is low.
module pe_link_packer
    import pe_link_pkg::*;
#(
    parameter int WORD_WIDTH     = 32,
    parameter int WORDS_PER_BEAT = 4,
    parameter int LINK_WIDTH     = 130,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ap_start,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [LINK_WIDTH-1:0] out_link,
    output logic [15:0]           beat_count,
    output logic [15:0]           pkt_count
);

    localparam int PW     = WORD_WIDTH * WORDS_PER_BEAT;
    localparam int LANE_W = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;

    if (LINK_WIDTH != PW + 2) begin : g_bad_link
        $error("pe_link_packer: LINK_WIDTH must equal WORD_WIDTH*WORDS_PER_BEAT+2");
    end
    if ((PW != PAYLOAD_WIDTH) || (LINK_WIDTH != $bits(link_beat_t))) begin : g_bad_pkg
        $error("pe_link_packer: parameters disagree with pe_link_pkg layout");
    end

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [PW-1:0]     lanes_q, lanes_d;
    link_beat_t        out_q, out_d;
    logic [15:0]       beat_count_q, beat_count_d;
    logic [15:0]       pkt_count_q, pkt_count_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    fifo_entry_t       push_entry;
    fifo_entry_t       pop_entry;

    logic              accept;
    logic              beat_done;
    logic [PW-1:0]     beat_payload;

    assign s_ready = ap_start & ~fifo_full & ~reset;

    // Packer: merge the accepted word into the lane register and detect beat completion.
    always_comb begin
        accept       = s_valid & s_ready;
        beat_payload = lanes_q;
        beat_payload[WORD_WIDTH*lane_q +: WORD_WIDTH] = s_data;
        beat_done    = accept && (s_last || (lane_q == LANE_W'(WORDS_PER_BEAT - 1)));

        fifo_push          = beat_done;
        push_entry.last    = s_last;
        push_entry.payload = beat_payload;

        lane_d  = lane_q;
        lanes_d = lanes_q;
        if (beat_done) begin
            lane_d  = '0;
            lanes_d = '0;
        end else if (accept) begin
            lane_d  = lane_q + LANE_W'(1);
            lanes_d = beat_payload;
        end
    end

    // Emitter: a popped beat reaches the link one edge after it entered the FIFO.
    always_comb begin
        fifo_pop     = ap_start && !fifo_empty;
        out_d        = out_q;
        beat_count_d = beat_count_q;
        pkt_count_d  = pkt_count_q;
        if (ap_start) begin
            if (!fifo_empty) begin
                out_d        = make_link_beat(pop_entry);
                beat_count_d = beat_count_q + 16'd1;
                pkt_count_d  = pkt_count_q + 16'(pop_entry.last);
            end else begin
                out_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q       <= '0;
            lanes_q      <= '0;
            out_q        <= '0;
            beat_count_q <= '0;
            pkt_count_q  <= '0;
        end else begin
            lane_q       <= lane_d;
            lanes_q      <= lanes_d;
            out_q        <= out_d;
            beat_count_q <= beat_count_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    pe_link_beat_fifo #(
        .WIDTH (PAYLOAD_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_beat_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .pop_data_o  (pop_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign out_link   = out_q;
    assign beat_count = beat_count_q;
    assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_pe_link_packer.sv
// Scoreboard bench for pe_link_packer: a queue-based packet model predicts every
// link cycle, plus a few directed checks with hand-computed link values.
module tb_pe_link_packer;

    logic         clk;
    logic         reset;
    logic         ap_start;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [129:0] out_link;
    logic [15:0]  beat_count;
    logic [15:0]  pkt_count;

    int n_tests = 0;
    int n_fail  = 0;

    pe_link_packer #(
        .WORD_WIDTH     (32),
        .WORDS_PER_BEAT (4),
        .LINK_WIDTH     (130),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ap_start   (ap_start),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .out_link   (out_link),
        .beat_count (beat_count),
        .pkt_count  (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: packets as word lists, completed beats in a queue,
    // evaluated once per clock edge from inputs sampled before that edge.
    typedef struct packed {
        logic         last;
        logic [127:0] payload;
    } beat_t;

    beat_t        exp_q[$];
    logic [31:0]  cur_w[$];
    logic [129:0] exp_out = '0;
    logic [15:0]  exp_bc  = '0;
    logic [15:0]  exp_pc  = '0;

    initial begin : monitor
        bit          cap_en = 0;
        logic        c_rst, c_ap, c_acc, c_last, exp_rdy;
        logic [31:0] c_data;
        beat_t       b;
        logic [127:0] pl;
        forever begin
            @(negedge clk);
            if (cap_en) begin
                if (c_rst) begin
                    exp_q.delete();
                    cur_w.delete();
                    exp_out = '0;
                    exp_bc  = '0;
                    exp_pc  = '0;
                end else if (c_ap) begin
                    if (exp_q.size() > 0) begin
                        b       = exp_q.pop_front();
                        exp_out = {1'b1, b.last, b.payload};
                        exp_bc  = exp_bc + 16'd1;
                        if (b.last) exp_pc = exp_pc + 16'd1;
                    end else begin
                        exp_out = '0;
                    end
                    if (c_acc) begin
                        cur_w.push_back(c_data);
                        if (cur_w.size() == 4 || c_last) begin
                            pl = '0;
                            foreach (cur_w[i]) pl[32*i +: 32] = cur_w[i];
                            exp_q.push_back({c_last, pl});
                            cur_w.delete();
                        end
                    end
                end
                check("out_link", out_link, exp_out);
                check("beat_count", {114'b0, beat_count}, {114'b0, exp_bc});
                check("pkt_count", {114'b0, pkt_count}, {114'b0, exp_pc});
            end
            exp_rdy = ap_start && !reset && (exp_q.size() < 4);
            check("s_ready", {129'b0, s_ready}, {129'b0, exp_rdy});
            c_rst  = reset;
            c_ap   = ap_start;
            c_acc  = s_valid && exp_rdy;
            c_data = s_data;
            c_last = s_last;
            cap_en = 1;
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0);
    endtask

    initial begin : stimulus
        reset    = 1'b1;
        ap_start = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_link", out_link, 130'h0);
        check("reset_beats", {114'b0, beat_count}, 130'h0);
        reset = 1'b0;

        // Four-word packet: beat on the link one edge after the last word.
        drive(1'b1, 32'h11, 1'b0);
        drive(1'b1, 32'h22, 1'b0);
        drive(1'b1, 32'h33, 1'b0);
        drive(1'b1, 32'h44, 1'b1);
        check("pkt4_not_yet", out_link, 130'h0);
        idle(1);
        check("pkt4_link", out_link,
              {2'b11, 128'h00000044_00000033_00000022_00000011});
        check("pkt4_beats", {114'b0, beat_count}, 130'd1);
        check("pkt4_pkts", {114'b0, pkt_count}, 130'd1);

        // Six-word packet splits into a full beat and a zero-padded tail.
        for (int i = 1; i <= 6; i++) drive(1'b1, 32'(i), i == 6);
        idle(1);
        check("pkt6_tail", out_link, {2'b11, 64'h0, 32'h6, 32'h5});
        check("pkt6_beats", {114'b0, beat_count}, 130'd3);
        check("pkt6_pkts", {114'b0, pkt_count}, 130'd2);

        // Freeze mid-stream with the stream still offering words.
        for (int i = 0; i < 6; i++) drive(1'b1, $urandom, 1'b0);
        ap_start = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'b1, $urandom, i == 9);
        ap_start = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, $urandom, i == 4);
        idle(4);

        // Reset mid-packet discards the partial lanes.
        drive(1'b1, 32'hDEAD0001, 1'b0);
        drive(1'b1, 32'hDEAD0002, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("rst_mid_link", out_link, 130'h0);
        check("rst_mid_pkts", {114'b0, pkt_count}, 130'h0);
        drive(1'b1, 32'hAB, 1'b1);
        idle(1);
        check("post_rst_beat", out_link, {2'b11, 96'h0, 32'hAB});

        // Randomized traffic with run-enable gaps and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            ap_start = ($urandom_range(0, 9) < 8);
            reset    = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 4) == 0);
        end
        reset    = 1'b0;
        ap_start = 1'b1;
        idle(4);

        // Counter wrap: 65537 single-word packets after a reset.
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        for (int i = 0; i < 65537; i++) drive(1'b1, 32'(i), 1'b1);
        idle(3);
        check("wrap_beats", {114'b0, beat_count}, 130'h1);
        check("wrap_pkts", {114'b0, pkt_count}, 130'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
